req_arbit_rr: RTL and testbench
===============================

Name: req_arbit_rr

Overview:
- Parametrised successor to the fixed 10-port request arbiter in the switch egress path.
- Arbitrates N port requests for one shared output FIFO / MAC data path, in two classes:
  - express (qbu-flagged) requests always win over normal requests;
  - within a class, grants rotate round-robin with an independent pointer per class.
- A grant is held until the data path signals frame completion; a watchdog force-releases a stuck grant.

Parameters:
- PORT_NUM, 10: number of requesting ports (2..32).
- QBU_PORT_NUM, 8: ports 0..QBU_PORT_NUM-1 honour the qbu flag; flag bits of higher ports are ignored (always normal class).
- IDX_W, $clog2(PORT_NUM): width of the granted-index output.
- TIMEOUT_CYC, 4096: watchdog limit in cycles for a held grant; 0 disables the watchdog.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_port_req  in  PORT_NUM  per-port request, level, held until granted.
- i_port_qbu_flag  in  PORT_NUM  per-port express (critical-frame) flag, qualified by i_port_req.
- i_data_ready  in  1  1 = downstream FIFO idle, 0 = busy.
- i_grant_done  in  1  single-cycle pulse: granted frame fully transferred.
- o_port_ack  out  PORT_NUM  one-hot grant vector, 0 when no grant.
- o_port_idx  out  IDX_W  binary index of the granted port.
- o_port_vld  out  1  grant valid.
- o_port_exp  out  1  current grant is express class.
- o_timeout  out  1  one-cycle pulse when the watchdog releases a grant.

Behaviour:
- Reset (i_rst=0, async): all outputs 0; FSM=IDLE; both RR pointers=0; watchdog counter=0.
- Qualified request sets:
  - exp = i_port_req & i_port_qbu_flag & QBU_MASK, where QBU_MASK sets bits 0..QBU_PORT_NUM-1.
  - nrm = i_port_req & ~exp.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If i_data_ready=1 and (exp|nrm)!=0: select the winner and go to GRANT.
  - If exp!=0, the winner is the first set bit of exp at or above ptr_exp, with wrap-around; otherwise the first set bit of nrm at or above ptr_nrm, with wrap-around.
- Latency: one cycle, registered. Request plus ready sampled at edge k; o_port_vld/o_port_ack/o_port_idx/o_port_exp are valid after edge k+1.
- Pointer update at grant: the winning class's pointer becomes (winner+1) mod PORT_NUM. The other class's pointer is unchanged.
- GRANT:
  - Outputs are held stable.
  - i_port_req, i_port_qbu_flag and i_data_ready are ignored; a request dropping does not release the grant.
  - i_grant_done=1 moves to GAP.
  - If TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 without done: pulse o_timeout and go to GAP.
  - The counter clears on entering GRANT.
  - Done and timeout in the same cycle: done wins, no o_timeout.
- GAP: one cycle with all grant outputs 0, then IDLE. This guarantees at least one idle cycle between grants.
- i_grant_done outside GRANT is ignored.
- i_data_ready=0 in IDLE: no grant is issued; requests stay pending.
- Single requester: re-granted after each GAP, so at most one grant per 3 cycles (IDLE, GRANT, GAP).
- Reset asserted mid-GRANT: outputs clear immediately (async); pointers return to 0.

Optional Feature:
- Macro REQ_ARB_PREEMPT_EN.
- When defined:
  - Adds output o_preempt (1 bit).
  - In GRANT with o_port_exp=0, o_preempt is asserted, registered, the cycle after any exp bit is set. It stays asserted until GRANT exits.
  - The data path uses o_preempt to fragment the frame (802.3br) and then pulses i_grant_done.
  - The next IDLE cycle grants the express requester.
- When undefined: the port and its logic are absent; a normal grant runs to completion regardless of express requests.

Test Plan:
- PORT_NUM=10, req=10'b00_0100_1011, flags=0, ready=0 for 20 cycles → o_port_vld stays 0. Then ready=1 with done pulsed 2 cycles after each grant → grant order 0,1,3,6,0.
- req=10'b00_0100_0100, qbu_flag=10'b00_0100_0000 → port 6 (express) is granted first. After done, port 2 is granted. With port 6 held, grants stay 6 only (express starvation of normal traffic is accepted).
- req=qbu_flag=10'b00_0010_1010 → express RR order 1,3,5,1. ptr_nrm stays 0: a later normal-only req=10'b01 grants port 0.
- req[9]=1, qbu_flag[9]=1 (port 9 is above QBU_PORT_NUM) alongside req[2]=1 → port 9 is treated as normal; RR order 2,9.
- TIMEOUT_CYC=16, grant port 4, no done → o_timeout pulses after exactly 16 GRANT cycles, then 1 GAP cycle, then re-arbitration. Done and timeout on the same cycle → no o_timeout.
- With REQ_ARB_PREEMPT_EN: normal grant to port 8, express req on port 0 at GRANT cycle 3 → o_preempt=1 from cycle 4. After done and GAP, port 0 is granted with o_port_exp=1.

Source files
------------

// File: rtl/req_arbit_rr.sv
// -----------------------------------------------------------------------------
// req_arbit_rr
//
// Two-class round-robin request arbiter for the switch egress path. PORT_NUM
// ports compete for one shared output FIFO / MAC data path.
//   * Express requests (qbu flag set, ports 0..QBU_PORT_NUM-1 only) always
//     beat normal requests.
//   * Inside a class the winner rotates round-robin; each class keeps its own
//     pointer, so express traffic never disturbs the normal rotation.
//   * A grant is held until i_grant_done; an optional watchdog releases a
//     grant that has been held for TIMEOUT_CYC cycles.
//   * Every grant is followed by one dead cycle, so grants are at least one
//     idle cycle apart.
//
// Optional feature (compile-time macro REQ_ARB_PREEMPT_EN):
//   Adds o_preempt. While a normal-class grant is active and an express
//   request appears, o_preempt rises one cycle later and stays high until the
//   grant ends, telling the data path to fragment the frame.
//
// Handshake: a grant is valid while o_port_vld=1; o_port_ack/o_port_idx/
// o_port_exp are stable for the whole grant. The data path ends the grant with
// a one-cycle i_grant_done pulse; o_port_vld drops on the next clock.
//
// Ports:
//   i_clk            system clock
//   i_rst            asynchronous reset, active low
//   i_port_req       per-port request level, held until granted
//   i_port_qbu_flag  per-port express flag, qualified by i_port_req
//   i_data_ready     1 = downstream FIFO idle and able to take a new frame
//   i_grant_done     one-cycle pulse: granted frame fully transferred
//   o_port_ack       one-hot grant vector, 0 without grant
//   o_port_idx       binary index of the granted port
//   o_port_vld       grant valid
//   o_port_exp       current grant belongs to the express class
//   o_timeout        one-cycle pulse when the watchdog releases a grant
//   o_preempt        (REQ_ARB_PREEMPT_EN only) fragment request for a normal grant
//   dbg_state        current FSM state (0 idle, 1 grant, 2 gap)
// -----------------------------------------------------------------------------
module req_arbit_rr #(
   parameter int PORT_NUM     = 10,
   parameter int QBU_PORT_NUM = 8,
   parameter int IDX_W        = $clog2(PORT_NUM),
   parameter int TIMEOUT_CYC  = 4096
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [PORT_NUM-1:0] i_port_req,
   input  logic [PORT_NUM-1:0] i_port_qbu_flag,
   input  logic                i_data_ready,
   input  logic                i_grant_done,
   output logic [PORT_NUM-1:0] o_port_ack,
   output logic [IDX_W-1:0]    o_port_idx,
   output logic                o_port_vld,
   output logic                o_port_exp,
   output logic                o_timeout,
`ifdef REQ_ARB_PREEMPT_EN
   output logic                o_preempt,
`endif
   output logic [1:0]          dbg_state
);

   // FSM encoding
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   // Ports at or above QBU_PORT_NUM can never be express.
   localparam logic [PORT_NUM-1:0] QBU_MASK =
      (QBU_PORT_NUM >= PORT_NUM) ? {PORT_NUM{1'b1}} :
                                   PORT_NUM'((64'd1 << QBU_PORT_NUM) - 64'd1);

   // Watchdog counter only needs to reach TIMEOUT_CYC-1.
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

   // Sum of pointer and offset needs one extra bit before wrapping.
   localparam int SW = IDX_W + 1;

   logic [1:0]          state;
   logic [IDX_W-1:0]    ptr_exp;
   logic [IDX_W-1:0]    ptr_nrm;
   logic [CNT_W-1:0]    wd_cnt;

   logic [PORT_NUM-1:0] exp_req;
   logic [PORT_NUM-1:0] nrm_req;
   logic                any_exp;
   logic                any_req;
   logic [IDX_W-1:0]    pick_exp;
   logic [IDX_W-1:0]    pick_nrm;
   logic [IDX_W-1:0]    win_idx;
   logic [PORT_NUM-1:0] win_onehot;
   logic                timeout_hit;

   // First set bit of vec at or above ptr, wrapping past PORT_NUM-1 to 0.
   // Returns 0 for an empty vector; callers only use it when vec is non-empty.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [PORT_NUM-1:0] vec,
                                                input logic [IDX_W-1:0]    ptr);
      logic [IDX_W-1:0] win;
      logic             found;
      logic [SW-1:0]    pos;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < PORT_NUM; i++) begin
         pos = {1'b0, ptr} + SW'(i);
         if (pos >= SW'(PORT_NUM))
            pos = pos - SW'(PORT_NUM);
         if (!found && vec[pos[IDX_W-1:0]]) begin
            found = 1'b1;
            win   = pos[IDX_W-1:0];
         end
      end
      return win;
   endfunction

   // Pointer moves to the port after the winner, modulo PORT_NUM.
   function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] w);
      return (w == IDX_W'(PORT_NUM - 1)) ? '0 : w + IDX_W'(1);
   endfunction

   always_comb begin
      exp_req    = i_port_req & i_port_qbu_flag & QBU_MASK;
      nrm_req    = i_port_req & ~exp_req;
      any_exp    = |exp_req;
      any_req    = |(exp_req | nrm_req);
      pick_exp   = rr_pick(exp_req, ptr_exp);
      pick_nrm   = rr_pick(nrm_req, ptr_nrm);
      win_idx    = any_exp ? pick_exp : pick_nrm;
      win_onehot = {{(PORT_NUM-1){1'b0}}, 1'b1} << win_idx;
   end

   // Watchdog fires on the TIMEOUT_CYC-th held cycle; disabled when 0.
   assign timeout_hit = (TIMEOUT_CYC != 0) && (wd_cnt == CNT_LAST);

   assign dbg_state = state;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state      <= S_IDLE;
         ptr_exp    <= '0;
         ptr_nrm    <= '0;
         wd_cnt     <= '0;
         o_port_ack <= '0;
         o_port_idx <= '0;
         o_port_vld <= 1'b0;
         o_port_exp <= 1'b0;
         o_timeout  <= 1'b0;
      end else begin
         o_timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_data_ready && any_req) begin
                  state      <= S_GRANT;
                  wd_cnt     <= '0;
                  o_port_vld <= 1'b1;
                  o_port_idx <= win_idx;
                  o_port_ack <= win_onehot;
                  o_port_exp <= any_exp;
                  // Only the winning class advances its rotation.
                  if (any_exp)
                     ptr_exp <= ptr_after(pick_exp);
                  else
                     ptr_nrm <= ptr_after(pick_nrm);
               end
            end

            S_GRANT: begin
               // Requests, flags and ready are deliberately not looked at
               // here: only done or the watchdog can end a grant.
               if (i_grant_done || timeout_hit) begin
                  state      <= S_GAP;
                  o_port_vld <= 1'b0;
                  o_port_idx <= '0;
                  o_port_ack <= '0;
                  o_port_exp <= 1'b0;
                  // Done on the last watchdog cycle still counts as a
                  // normal completion.
                  o_timeout  <= !i_grant_done;
               end else begin
                  wd_cnt <= wd_cnt + CNT_W'(1);
               end
            end

            S_GAP: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef REQ_ARB_PREEMPT_EN
   // Sticky for the rest of a normal grant once any express request shows up;
   // cleared on the edge that leaves GRANT.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_preempt <= 1'b0;
      end else begin
         o_preempt <= (state == S_GRANT) && !(i_grant_done || timeout_hit) &&
                      (o_preempt || (!o_port_exp && any_exp));
      end
   end
`endif

endmodule

// File: tb/tb_req_arbit_rr.sv
module tb_req_arbit_rr;

   localparam int N    = 10;
   localparam int QBU  = 8;
   localparam int IW   = 4;
   localparam int TMO  = 16;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [N-1:0]  port_req      = '0;
   logic [N-1:0]  port_qbu_flag = '0;
   logic          data_ready    = 1'b0;
   logic          man_done      = 1'b0;
   logic          auto_pulse    = 1'b0;
   logic          auto_en       = 1'b0;
   logic          grant_done;
   logic [N-1:0]  port_ack;
   logic [IW-1:0] port_idx;
   logic          port_vld;
   logic          port_exp;
   logic          timeout;
   logic [1:0]    dbg_state;
`ifdef REQ_ARB_PREEMPT_EN
   logic          preempt;
`endif

   assign grant_done = man_done | auto_pulse;

   req_arbit_rr #(
      .PORT_NUM     (N),
      .QBU_PORT_NUM (QBU),
      .IDX_W        (IW),
      .TIMEOUT_CYC  (TMO)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst_n),
      .i_port_req      (port_req),
      .i_port_qbu_flag (port_qbu_flag),
      .i_data_ready    (data_ready),
      .i_grant_done    (grant_done),
      .o_port_ack      (port_ack),
      .o_port_idx      (port_idx),
      .o_port_vld      (port_vld),
      .o_port_exp      (port_exp),
      .o_timeout       (timeout),
`ifdef REQ_ARB_PREEMPT_EN
      .o_preempt       (preempt),
`endif
      .dbg_state       (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic chk_en = 1'b0;
   logic [IW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
      n_checks++;
      if (act === req_v)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, required 0x%0h at time %0t", name, act, req_v, $time);
   endtask

   // ---------------- behavioural reference model ----------------
   // Grant holder (-1 none), class of the grant, cycles held, gap flag,
   // one pointer per class as plain integers.
   int   m_gnt   = -1;
   logic m_exp   = 1'b0;
   int   m_held  = 0;
   logic m_gap   = 1'b0;
   logic m_tmo   = 1'b0;
   int   m_ptr_e = 0;
   int   m_ptr_n = 0;
`ifdef REQ_ARB_PREEMPT_EN
   logic m_pre   = 1'b0;
`endif

   function automatic int first_from(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_end_grant();
      m_gnt = -1;
      m_exp = 1'b0;
      m_gap = 1'b1;
`ifdef REQ_ARB_PREEMPT_EN
      m_pre = 1'b0;
`endif
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_gnt = -1; m_exp = 1'b0; m_held = 0; m_gap = 1'b0; m_tmo = 1'b0;
         m_ptr_e = 0; m_ptr_n = 0;
`ifdef REQ_ARB_PREEMPT_EN
         m_pre = 1'b0;
`endif
      end else begin
         logic [N-1:0] ev;
         logic [N-1:0] nv;
         int w;
         ev = '0;
         for (int p = 0; p < N; p++)
            ev[p] = port_req[p] && port_qbu_flag[p] && (p < QBU);
         nv = port_req & ~ev;
         m_tmo = 1'b0;
         if (m_gnt >= 0) begin
            m_held++;
            if (grant_done) begin
               model_end_grant();
            end else if (m_held == TMO) begin
               model_end_grant();
               m_tmo = 1'b1;
            end
`ifdef REQ_ARB_PREEMPT_EN
            else if (!m_exp && ev != 0) begin
               m_pre = 1'b1;
            end
`endif
         end else if (m_gap) begin
            m_gap = 1'b0;
         end else if (data_ready && port_req != 0) begin
            if (ev != 0) begin
               w = first_from(ev, m_ptr_e);
               m_ptr_e = (w + 1) % N;
               m_exp = 1'b1;
            end else begin
               w = first_from(nv, m_ptr_n);
               m_ptr_n = (w + 1) % N;
               m_exp = 1'b0;
            end
            m_gnt  = w;
            m_held = 0;
         end
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [31:0] act;
         logic [31:0] mdl;
         logic [N-1:0] m_ack;
         logic [1:0] m_st;
         m_ack = (m_gnt >= 0) ? (N'(1) << m_gnt) : '0;
         m_st  = (m_gnt >= 0) ? 2'd1 : (m_gap ? 2'd2 : 2'd0);
         act = {12'd0, port_vld, port_exp, timeout, port_idx, port_ack, dbg_state};
         mdl = {12'd0, (m_gnt >= 0), m_exp, m_tmo,
                (m_gnt >= 0) ? IW'(m_gnt) : IW'(0), m_ack, m_st};
`ifdef REQ_ARB_PREEMPT_EN
         act[31] = preempt;
         mdl[31] = m_pre;
`endif
         check("cycle_outputs", act, mdl);
      end
   end

   // Grant-order scoreboard against hand-computed sequences.
   logic prev_vld = 1'b0;
   always @(negedge clk) begin
      if (chk_en && port_vld && !prev_vld && exp_q.size() > 0)
         check("grant_order", 32'(port_idx), 32'(exp_q.pop_front()));
      prev_vld = port_vld;
   end

   // Responder: pulse done in the second cycle of each grant when enabled.
   int gcnt = 0;
   always @(posedge clk) begin
      #2;
      if (port_vld) gcnt++;
      else gcnt = 0;
      auto_pulse = auto_en && port_vld && (gcnt == 2);
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      port_req = '0; port_qbu_flag = '0; data_ready = 1'b0;
      man_done = 1'b0; auto_en = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic wait_vld(input string name, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (port_vld) break;
      end
      check(name, 32'(port_vld), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int z;
      #1;
      rst_n = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_state", {port_vld, port_exp, timeout, port_idx, port_ack, dbg_state}, 32'd0);
      do_reset();

      // Ready low blocks grants; then normal RR order 0,1,3,6,0.
      port_req = 10'b00_0100_1011;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (port_vld) n++;
      end
      check("no_grant_while_busy", 32'(n), 32'd0);
      @(posedge clk); #2;
      exp_q = '{4'd0, 4'd1, 4'd3, 4'd6, 4'd0};
      data_ready = 1'b1; auto_en = 1'b1;
      drain("rr_normal", 100);

      // Express beats normal; express holder starves normal traffic.
      do_reset();
      port_req = 10'b00_0100_0100; port_qbu_flag = 10'b00_0100_0000;
      data_ready = 1'b1; auto_en = 1'b1;
      exp_q = '{4'd6};
      drain("express_first", 30);
      port_req = 10'b00_0000_0100; port_qbu_flag = '0;
      exp_q = '{4'd2};
      drain("normal_after_express", 30);
      port_req = 10'b00_0100_0100; port_qbu_flag = 10'b00_0100_0000;
      exp_q = '{4'd6, 4'd6, 4'd6};
      drain("express_starves", 60);

      // Express RR 1,3,5,1; normal pointer untouched (0 beats 9).
      do_reset();
      port_req = 10'b00_0010_1010; port_qbu_flag = 10'b00_0010_1010;
      data_ready = 1'b1; auto_en = 1'b1;
      exp_q = '{4'd1, 4'd3, 4'd5, 4'd1};
      drain("rr_express", 60);
      port_req = 10'b10_0000_0001; port_qbu_flag = '0;
      exp_q = '{4'd0};
      drain("nrm_ptr_kept", 30);

      // Port 9 flag ignored: normal RR 2,9,2.
      do_reset();
      port_req = 10'b10_0000_0100; port_qbu_flag = 10'b10_0000_0000;
      data_ready = 1'b1; auto_en = 1'b1;
      exp_q = '{4'd2, 4'd9, 4'd2};
      drain("high_port_normal", 60);

      // Watchdog: 16 held cycles, pulse in the gap, re-grant two cycles later.
      do_reset();
      port_req = 10'b00_0001_0000; data_ready = 1'b1;
      wait_vld("tmo_grant_seen", 20);
      check("tmo_grant_port", 32'(port_idx), 32'd4);
      n = 0;
      while (port_vld && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("tmo_grant_len", 32'(n), 32'd16);
      check("tmo_pulse", 32'(timeout), 32'd1);
      z = 0;
      while (!port_vld && z < 20) begin
         z++;
         @(negedge clk);
      end
      check("tmo_regrant_gap", 32'(z), 32'd2);
      // Done on the 16th held cycle: no timeout pulse.
      repeat (15) @(negedge clk);
      check("tmo_still_held", 32'(port_vld), 32'd1);
      man_done = 1'b1;
      @(posedge clk); #2;
      man_done = 1'b0;
      @(negedge clk);
      check("done_beats_timeout", {port_vld, timeout}, 32'd0);

      // Async reset mid-grant clears outputs and both pointers.
      do_reset();
      port_req = 10'b00_0000_1000; data_ready = 1'b1;
      wait_vld("arst_grant_seen", 20);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_clear", {port_vld, port_ack}, 32'd0);
      port_req = 10'b00_0001_1000;
      exp_q = '{4'd3};
      @(posedge clk); #2;
      rst_n = 1'b1;
      drain("ptr_after_reset", 20);

`ifdef REQ_ARB_PREEMPT_EN
      // Normal grant to port 8, express request on port 0 in grant cycle 3.
      do_reset();
      port_req = 10'b01_0000_0000; data_ready = 1'b1;
      wait_vld("pre_grant_seen", 20);
      check("pre_grant_port", 32'(port_idx), 32'd8);
      @(posedge clk); #2;
      @(posedge clk); #2;
      port_req = 10'b01_0000_0001; port_qbu_flag = 10'b00_0000_0001;
      @(negedge clk);
      check("preempt_cycle3", 32'(preempt), 32'd0);
      @(negedge clk);
      check("preempt_cycle4", 32'(preempt), 32'd1);
      @(posedge clk); #2;
      man_done = 1'b1; port_req = 10'b00_0000_0001;
      exp_q = '{4'd0};
      @(posedge clk); #2;
      man_done = 1'b0;
      drain("preempt_regrant", 20);
      check("preempt_grant_exp", 32'(port_exp), 32'd1);
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #2;
         port_req      = N'($urandom) & N'($urandom);
         port_qbu_flag = N'($urandom);
         data_ready    = ($urandom_range(0, 3) != 0);
         man_done      = ($urandom_range(0, 5) == 0);
      end
      @(posedge clk); #2;
      man_done = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
